// File: rtl/adc_hyst_comp.sv
// Decimated ADC block averager with a hysteresis comparator on the block mean.
// Drops the first SKIP_BLOCKS blocks of every run so start-up transients never reach ADC_comp.
module adc_hyst_comp #(
    parameter int               ADC_W       = 12,
    parameter int               PERIOD      = 200,
    parameter int               AVG_LOG2    = 2,
    parameter logic [ADC_W-1:0] TH_HI       = 12'h880,
    parameter logic [ADC_W-1:0] TH_LO       = 12'h780,
    parameter int               SKIP_BLOCKS = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             swiptAlive,
    input  logic [ADC_W-1:0] ADC,
    output logic             ADC_comp,
    output logic             comp_valid,
    output logic [ADC_W-1:0] adc_mean,
    output logic             sample_stb
);

    localparam int CW = $clog2(PERIOD);
    localparam int AW = ADC_W + AVG_LOG2;
    localparam int SW = AVG_LOG2 + 1;

    localparam logic [CW-1:0] RELOAD   = CW'(PERIOD - 1);
    localparam logic [SW-1:0] LAST     = SW'((1 << AVG_LOG2) - 1);
    localparam logic [3:0]    SKIP_MAX = 4'(SKIP_BLOCKS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DECIDE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [ADC_W-1:0] r_adc_q;
    logic [AW-1:0]    r_acc;
    logic [AW-1:0]    r_lat;
    logic [SW-1:0]    r_scnt;
    logic [3:0]       r_skip;
    logic             r_comp;
    logic             r_valid;
    logic [ADC_W-1:0] r_mean;

    logic [AW-1:0]    w_sum;
    logic [ADC_W-1:0] w_mean;
    logic             w_stb;
    logic             w_last;
    logic             w_decide;
    logic             w_eval;

    assign w_stb    = (r_state != IDLE) && (r_cnt == '0);
    assign w_last   = w_stb && (r_scnt == LAST);
    assign w_sum    = r_acc + AW'(r_adc_q);
    assign w_mean   = r_lat[AVG_LOG2 +: ADC_W];
    assign w_decide = (r_state == DECIDE);
    assign w_eval   = w_decide && (r_skip >= SKIP_MAX);

    assign sample_stb = w_stb;
    assign ADC_comp   = r_comp;
    assign comp_valid = r_valid;
    assign adc_mean   = r_mean;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else if (!swiptAlive) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (swiptAlive) w_next = RUN;
            RUN:     if (w_last) w_next = DECIDE;
            DECIDE:  w_next = RUN;
            default: w_next = IDLE;
        endcase
    end

    // Free-running decimation counter; keeps counting through DECIDE.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= RELOAD;
        end else if (!swiptAlive || r_state == IDLE) begin
            r_cnt <= RELOAD;
        end else if (r_cnt == '0) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_adc_q <= '0;
            r_acc   <= '0;
            r_lat   <= '0;
            r_scnt  <= '0;
            r_skip  <= '0;
            r_valid <= 1'b0;
            r_mean  <= '0;
            r_comp  <= 1'b0;
        end else if (!swiptAlive) begin
            r_adc_q <= '0;
            r_acc   <= '0;
            r_lat   <= '0;
            r_scnt  <= '0;
            r_skip  <= '0;
            r_valid <= 1'b0;
            r_mean  <= '0;
            r_comp  <= 1'b0;
        end else begin
            r_adc_q <= ADC;
            r_valid <= w_eval;
            if (w_stb) begin
                r_acc  <= w_sum;
                r_scnt <= r_scnt + 1'b1;
                if (w_last) r_lat <= w_sum;
            end
            if (w_decide) begin
                r_acc  <= '0;
                r_scnt <= '0;
                if (r_skip < SKIP_MAX) r_skip <= r_skip + 1'b1;
            end
            // Between the thresholds the previous decision is held.
            if (w_eval) begin
                r_mean <= w_mean;
                if (w_mean <= TH_LO) begin
                    r_comp <= 1'b1;
                end else if (w_mean >= TH_HI) begin
                    r_comp <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_hyst_comp.sv
// Scoreboard bench for adc_hyst_comp: a block-level reference model queues
// expected decisions, an independent monitor checks them and the strobe timing.
module tb_adc_hyst_comp;

    localparam int          P     = 8;
    localparam logic [11:0] TH_HI = 12'h880;
    localparam logic [11:0] TH_LO = 12'h780;

    logic        clk = 1'b0;
    logic        nrst;
    logic        swiptAlive;
    logic [11:0] ADC;
    logic        ADC_comp;
    logic        comp_valid;
    logic [11:0] adc_mean;
    logic        sample_stb;

    always #5 clk = ~clk;

    adc_hyst_comp #(
        .ADC_W      (12),
        .PERIOD     (P),
        .AVG_LOG2   (2),
        .TH_HI      (TH_HI),
        .TH_LO      (TH_LO),
        .SKIP_BLOCKS(1)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .swiptAlive(swiptAlive),
        .ADC       (ADC),
        .ADC_comp  (ADC_comp),
        .comp_valid(comp_valid),
        .adc_mean  (adc_mean),
        .sample_stb(sample_stb)
    );

    typedef struct packed {
        logic [11:0] mean;
        logic        comp;
    } exp_t;

    exp_t q[$];
    exp_t e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int run_start = 0;
    int last_stb  = 0;
    bit first_pending = 1'b0;
    bit prev_cv = 1'b0;
    int n_dec = 0;
    int n_exp = 0;

    int m_sum;
    int m_n;
    int m_skip;
    bit m_comp;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_sum  = 0;
        m_n    = 0;
        m_skip = 0;
        m_comp = 1'b0;
    endtask

    // Reference: mean of each 4-sample block, hysteresis on that mean.
    task automatic model_sample(input int v);
        int mean;
        m_sum += v;
        m_n++;
        if (m_n == 4) begin
            if (m_skip < 1) begin
                m_skip++;
            end else begin
                mean = m_sum / 4;
                if (mean <= int'(TH_LO)) m_comp = 1'b1;
                else if (mean >= int'(TH_HI)) m_comp = 1'b0;
                q.push_back('{mean: 12'(mean), comp: m_comp});
                n_exp++;
            end
            m_n   = 0;
            m_sum = 0;
        end
    endtask

    task automatic sample(input int v);
        ADC = 12'(v);
        model_sample(v);
        repeat (P) @(negedge clk);
    endtask

    task automatic do_block(input int v);
        repeat (4) sample(v);
    endtask

    task automatic start_run();
        run_start     = cyc;
        first_pending = 1'b1;
        swiptAlive    = 1'b1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_comp"}, ADC_comp, 0);
        chk({tag, "_valid"}, comp_valid, 0);
        chk({tag, "_mean"}, adc_mean, 0);
        chk({tag, "_stb"}, sample_stb, 0);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sample_stb) begin
            if (first_pending) begin
                chk("first_stb_delay", cyc - run_start, P);
                first_pending = 1'b0;
            end else begin
                chk("stb_gap", cyc - last_stb, P);
            end
            last_stb = cyc;
        end
        if (comp_valid) begin
            n_dec++;
            chk("cv_single_cycle", prev_cv, 0);
            if (q.size() == 0) begin
                chk("cv_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                chk("adc_mean", adc_mean, e.mean);
                chk("ADC_comp", ADC_comp, e.comp);
            end
        end
        prev_cv = comp_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        nrst       = 1'b0;
        swiptAlive = 1'b0;
        ADC        = '0;
        model_clear();
        #2;
        chk_cleared("por");
        repeat (3) @(negedge clk);

        ADC = 12'h100;
        start_run();
        nrst = 1'b1;
        do_block(12'h100);
        do_block(12'h100);

        do_block(12'h700);
        do_block(12'h800);
        do_block(12'h880);
        do_block(12'h800);
        do_block(12'h780);

        sample(12'h87F);
        repeat (3) sample(12'h880);

        sample(12'h100);
        sample(12'h100);
        @(negedge clk);
        swiptAlive = 1'b0;
        model_clear();
        @(negedge clk);
        chk("abort_comp", ADC_comp, 0);
        chk("abort_mean", adc_mean, 0);
        chk("abort_valid", comp_valid, 0);
        repeat (3) @(negedge clk);

        start_run();
        do_block(12'h200);
        do_block(12'h900);
        sample(12'h87F);
        repeat (3) sample(12'h880);

        repeat (3) do_block(12'hFFF);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(7) == 0) sample(int'($urandom_range(12'hFFF)));
            else sample(int'($urandom_range(12'hA00, 12'h600)));
        end

        do_block(12'h100);
        do_block(12'h300);
        @(posedge clk);
        #2;
        nrst = 1'b0;
        void'(q.pop_back());
        n_exp--;
        model_clear();
        #1;
        chk_cleared("decide_rst");
        repeat (3) @(negedge clk);

        ADC = 12'h100;
        start_run();
        nrst = 1'b1;
        do_block(12'h100);
        do_block(12'h100);

        repeat (6) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("decision_count", n_dec, n_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_hyst_comp.md
Name: adc_hyst_comp

Overview:
Parametrised successor to the SWIPT-side ADC midscale comparator. It samples the ADC word on a programmable decimation period and averages 2^AVG_LOG2 samples per block. A hysteresis window on the block mean produces the ADC_comp decision bit, with a valid strobe, for the PLL/SWIPT control loop. It discards the first SKIP_BLOCKS blocks after each swiptAlive assertion so start-up transients do not reach the decision.

Parameters:
ADC_W, 12, ADC word width (bits)
PERIOD, 200, clk cycles between sample strobes; legal range >= 2
AVG_LOG2, 2, log2 of samples averaged per block; legal range 0..4
TH_HI, 12'h880, mean >= TH_HI drives ADC_comp to 0
TH_LO, 12'h780, mean <= TH_LO drives ADC_comp to 1; TH_LO < TH_HI is required
SKIP_BLOCKS, 1, blocks discarded after each run start; legal range 0..15

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  reset, asynchronous, active-low
swiptAlive  input  1  run enable; low clears all state synchronously
ADC  input  ADC_W  raw ADC sample, unsigned
ADC_comp  output  1  hysteresis decision; 1 = signal low, 0 = signal high
comp_valid  output  1  one-cycle pulse when a block decision is evaluated
adc_mean  output  ADC_W  last evaluated block mean
sample_stb  output  1  one-cycle pulse on each sample capture

Behaviour:
- Reset: nrst low asynchronously forces every register to 0: ADC_q, acc, sample count, skip count, comp_valid, adc_mean, ADC_comp. The state goes to IDLE and the counter loads PERIOD-1.
- ADC is registered into ADC_q every clk cycle. All arithmetic uses ADC_q, so there is one cycle of input latency.
- swiptAlive low (sampled at clk) gives the same clear as reset, synchronously, from any state. The clear takes priority over every other event in that cycle.
- State machine: IDLE, RUN, DECIDE.
  - IDLE: when swiptAlive is high, go to RUN and load counter = PERIOD-1.
  - RUN/DECIDE: the counter decrements each cycle. At 0 it reloads PERIOD-1 and asserts sample_stb for that cycle. The counter runs freely across DECIDE; PERIOD >= 2 guarantees no strobe falls in DECIDE.
- Sample strobe:
  - acc += ADC_q. acc is ADC_W+AVG_LOG2 bits wide and cannot overflow.
  - The sample count increments.
  - On the 2^AVG_LOG2-th sample, acc (including that sample) is latched for evaluation, and next state = DECIDE.
- DECIDE (exactly one cycle):
  - mean = latched_acc >> AVG_LOG2, truncated, no rounding.
  - acc and the sample count are cleared, and the state returns to RUN.
  - If skip count < SKIP_BLOCKS: increment skip count. No output changes and no comp_valid.
  - Otherwise:
    - adc_mean <= mean.
    - comp_valid = 1 for this cycle only.
    - ADC_comp <= 1 if mean <= TH_LO; 0 if mean >= TH_HI; otherwise hold.
- Latency: comp_valid rises on the clk edge one cycle after the final sample_stb of a block.
- First decision: made after (SKIP_BLOCKS+1)*2^AVG_LOG2 strobes. The first strobe occurs PERIOD cycles after swiptAlive is first sampled high.
- Boundaries:
  - mean == TH_LO gives 1; mean == TH_HI gives 0.
  - ADC all-ones sustained gives mean = 2^ADC_W-1 with no wrap.
  - swiptAlive dropping mid-block discards the partial block. The next run restarts the skip count.
  - nrst asserted during DECIDE: no comp_valid is emitted.
  - AVG_LOG2 = 0: every strobe is a block; mean = sample.
- The skip count saturates at SKIP_BLOCKS.

Test Plan:
All scenarios use ADC_W=12, PERIOD=8, AVG_LOG2=2, TH_HI=0x880, TH_LO=0x780, SKIP_BLOCKS=1.
1. Reset check: nrst low mid-cycle, then released with swiptAlive=1 and ADC=0x100 -> all outputs 0 asynchronously. First sample_stb 8 cycles after swiptAlive is sampled high. First comp_valid after the 8th strobe (block 0 skipped), with adc_mean=0x100 and ADC_comp=1.
2. Hysteresis sweep: ADC steady at 0x700, 0x800, 0x880, 0x800, 0x780, one block each after skip -> ADC_comp = 1, 1 (hold), 0, 0 (hold), 1. adc_mean tracks each value exactly.
3. Averaging/truncation: samples 0x87F, 0x880, 0x880, 0x880 -> sum 0x21FF, mean 0x87F. ADC_comp holds its previous value (0x87F < TH_HI).
4. Saturation: ADC=0xFFF for 3 blocks -> adc_mean=0xFFF, ADC_comp=0, no wrap.
5. Mid-block abort: swiptAlive low after 2 strobes of a decision block, then high -> ADC_comp=0 and adc_mean=0 on the next cycle. No comp_valid. A fresh skip block runs before the next decision.
6. Strobe spacing: sample_stb is exactly 8 cycles apart across DECIDE cycles. comp_valid is never asserted in two consecutive cycles.
